// File: rtl/mem_stage_p_pkg.sv
// Shared widths, depth and latency choices for the memory stage and its RAM.
package mem_stage_p_pkg;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_REG_ADDR_W   = 3;
  localparam int DEF_MEM_DEPTH    = 4096;
  localparam int LAT_ONE          = 1;
  localparam int LAT_TWO          = 2;
  localparam int DEF_READ_LATENCY = LAT_ONE;

  // What an accepted operation delivers once it reaches the output.
  typedef enum logic [1:0] {
    OP_ALU = 2'd0,
    OP_MEM = 2'd1,
    OP_ERR = 2'd2
  } op_kind_e;

  function automatic bit legal_latency(input int lat);
    return (lat == LAT_ONE) || (lat == LAT_TWO);
  endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Single-port data RAM with synchronous write and an enabled, write-first read register.
module mem_stage_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = 12
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // A store returns its own data, so a later load of the same word sees it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (en_i) begin
      rdata_q <= we_i ? wdata_i : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage_p.sv
// Pipelined memory stage: loads, stores and ALU pass-through with a single
// global advance so every stage, including the RAM read register, stalls together.
module mem_stage_p
  import mem_stage_p_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  read_enable,
  input  logic                  write_enable,
  input  logic                  write_reg,
  input  logic [REG_ADDR_W-1:0] reg_address,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     read_out_data,
  output logic                  write_reg_out,
  output logic [REG_ADDR_W-1:0] reg_address_out,
  output logic                  addr_error
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  if (!legal_latency(READ_LATENCY)) begin : g_bad_latency
    $error("mem_stage_p: READ_LATENCY must be 1 or 2");
  end

  // Handshake: upstream holds an operation while in_valid && !in_ready and it
  // transfers on a rising edge with in_valid && in_ready; downstream likewise
  // takes a result on a rising edge with out_valid && out_ready.
  logic     advance;
  logic     accept;
  logic     in_range;
  logic     ram_we;
  op_kind_e in_kind;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance && !reset;
  assign in_range = {1'b0, address} < DEPTH_LIM;
  assign ram_we   = accept && write_enable && in_range;

  always_comb begin
    in_kind = OP_ALU;
    if (read_enable || write_enable) begin
      in_kind = in_range ? OP_MEM : OP_ERR;
    end
  end

  logic                  s1_valid_q, s1_valid_d;
  op_kind_e              s1_kind_q;
  logic [DATA_W-1:0]     s1_alu_q;
  logic                  s1_wreg_q;
  logic [REG_ADDR_W-1:0] s1_rega_q;

  assign s1_valid_d = advance ? accept : s1_valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_kind_q  <= OP_ALU;
      s1_alu_q   <= '0;
      s1_wreg_q  <= 1'b0;
      s1_rega_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (advance) begin
        s1_kind_q <= in_kind;
        s1_alu_q  <= alu_result;
        s1_wreg_q <= write_reg;
        s1_rega_q <= reg_address;
      end
    end
  end

  logic [DATA_W-1:0] ram_rdata;

  mem_stage_ram #(
    .DATA_W(DATA_W),
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_i  (clock),
    .en_i   (advance),
    .we_i   (ram_we),
    .addr_i (address[IDX_W-1:0]),
    .wdata_i(store_data),
    .rdata_o(ram_rdata)
  );

  logic [DATA_W-1:0] s1_data;
  logic              s1_err;
  logic              s1_wreg_vis;

  // Bubbles and out-of-range accesses present zero data.
  always_comb begin
    s1_data = '0;
    if (s1_valid_q) begin
      case (s1_kind_q)
        OP_ALU:  s1_data = s1_alu_q;
        OP_MEM:  s1_data = ram_rdata;
        default: s1_data = '0;
      endcase
    end
  end

  assign s1_err      = s1_valid_q && (s1_kind_q == OP_ERR);
  assign s1_wreg_vis = s1_valid_q && s1_wreg_q;

  if (READ_LATENCY == LAT_TWO) begin : g_lat2
    logic                  s2_valid_q;
    logic [DATA_W-1:0]     s2_data_q;
    logic                  s2_err_q;
    logic                  s2_wreg_q;
    logic [REG_ADDR_W-1:0] s2_rega_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
        s2_err_q   <= 1'b0;
        s2_wreg_q  <= 1'b0;
        s2_rega_q  <= '0;
      end else if (advance) begin
        s2_valid_q <= s1_valid_q;
        s2_data_q  <= s1_data;
        s2_err_q   <= s1_err;
        s2_wreg_q  <= s1_wreg_vis;
        s2_rega_q  <= s1_rega_q;
      end
    end

    assign out_valid       = s2_valid_q;
    assign read_out_data   = s2_data_q;
    assign addr_error      = s2_err_q;
    assign write_reg_out   = s2_wreg_q;
    assign reg_address_out = s2_rega_q;
  end else begin : g_lat1
    assign out_valid       = s1_valid_q;
    assign read_out_data   = s1_data;
    assign addr_error      = s1_err;
    assign write_reg_out   = s1_wreg_vis;
    assign reg_address_out = s1_rega_q;
  end

endmodule

// File: tb/tb_mem_stage_p.sv
// Bench for mem_stage_p: three instances (16b/lat1, 16b/lat2, 32b/lat1) exercised in turn
// against a word-addressed memory model and a slot queue of expected output beats.
module tb_mem_stage_p;

  localparam int ND    = 3;
  localparam int DEPTH = 4096;

  typedef struct packed {
    logic        v;
    logic        known;
    logic        err;
    logic        wreg;
    logic [2:0]  rega;
    logic [31:0] data;
  } exp_t;

  // clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [ND];
  logic        iv   [ND];
  logic        re   [ND];
  logic        we   [ND];
  logic        wr   [ND];
  logic [2:0]  ra   [ND];
  logic [15:0] ad   [ND];
  logic [31:0] sd   [ND];
  logic [31:0] alu  [ND];
  logic        ordy [ND];

  logic        irdy [ND];
  logic        ov   [ND];
  logic        wro  [ND];
  logic        aerr [ND];
  logic [2:0]  rao  [ND];
  logic [15:0] rd0, rd1;
  logic [31:0] rd2;

  mem_stage_p #(.DATA_W(16), .READ_LATENCY(1)) dut0 (
    .clock(clk), .reset(rst[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
    .address(ad[0]), .store_data(sd[0][15:0]), .alu_result(alu[0][15:0]),
    .read_enable(re[0]), .write_enable(we[0]), .write_reg(wr[0]), .reg_address(ra[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .read_out_data(rd0),
    .write_reg_out(wro[0]), .reg_address_out(rao[0]), .addr_error(aerr[0])
  );

  mem_stage_p #(.DATA_W(16), .READ_LATENCY(2)) dut1 (
    .clock(clk), .reset(rst[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
    .address(ad[1]), .store_data(sd[1][15:0]), .alu_result(alu[1][15:0]),
    .read_enable(re[1]), .write_enable(we[1]), .write_reg(wr[1]), .reg_address(ra[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .read_out_data(rd1),
    .write_reg_out(wro[1]), .reg_address_out(rao[1]), .addr_error(aerr[1])
  );

  mem_stage_p #(.DATA_W(32), .READ_LATENCY(1)) dut2 (
    .clock(clk), .reset(rst[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
    .address(ad[2]), .store_data(sd[2]), .alu_result(alu[2]),
    .read_enable(re[2]), .write_enable(we[2]), .write_reg(wr[2]), .reg_address(ra[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .read_out_data(rd2),
    .write_reg_out(wro[2]), .reg_address_out(rao[2]), .addr_error(aerr[2])
  );

  int tests_run = 0;
  int failed    = 0;

  exp_t        exp_q [$];
  logic [31:0] mem_m [int];

  function automatic int lat_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] mask_of(input int d);
    return (d == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    case (d)
      0:       return {16'h0, rd0};
      1:       return {16'h0, rd1};
      default: return rd2;
    endcase
  endfunction

  // scoreboard
  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s dut%0d t=%0t: observed %0h expected %0h", tag, d, $time, obs, expv);
    end
  endtask

  task automatic check_outputs(input int d);
    exp_t e;
    e = exp_q[$];
    chk("out_valid", d, 32'(ov[d]), 32'(e.v));
    chk("in_ready", d, 32'(irdy[d]), 32'(!e.v || ordy[d]));
    chk("addr_error", d, 32'(aerr[d]), 32'(e.v && e.err));
    chk("write_reg_out", d, 32'(wro[d]), 32'(e.v && e.wreg));
    if (e.v) begin
      chk("reg_address_out", d, 32'(rao[d]), 32'(e.rega));
      if (e.known) chk("read_out_data", d, rdata_of(d), e.data);
    end
  endtask

  // Builds the expected beat of an operation accepted now and applies its store to the model.
  function automatic exp_t model_op(input int d);
    exp_t        e;
    logic [31:0] m;
    int          a;
    m       = mask_of(d);
    a       = int'(ad[d]);
    e       = '0;
    e.v     = 1'b1;
    e.known = 1'b1;
    e.wreg  = wr[d];
    e.rega  = ra[d];
    if (re[d] || we[d]) begin
      if (a >= DEPTH) begin
        e.err  = 1'b1;
        e.data = 32'h0;
      end else if (we[d]) begin
        mem_m[a] = sd[d] & m;
        e.data   = sd[d] & m;
      end else if (mem_m.exists(a)) begin
        e.data = mem_m[a];
      end else begin
        e.known = 1'b0;
      end
    end else begin
      e.data = alu[d] & m;
    end
    return e;
  endfunction

  task automatic clear_slots(input int d);
    exp_q.delete();
    for (int i = 0; i < lat_of(d); i++) exp_q.push_back('0);
  endtask

  // One clock: check at the falling edge, advance the model on the rising edge.
  task automatic cycle(input int d, output logic acc);
    logic adv;
    exp_t ne;
    @(negedge clk);
    check_outputs(d);
    adv = !exp_q[$].v || ordy[d];
    acc = adv && iv[d];
    ne  = '0;
    if (acc) ne = model_op(d);
    @(posedge clk);
    if (adv) begin
      exp_q.push_front(ne);
      void'(exp_q.pop_back());
    end
    #1;
  endtask

  // driver tasks
  task automatic set_op(input int d, input logic r, input logic w, input logic [15:0] a,
                        input logic [31:0] s, input logic [31:0] al, input logic g, input logic [2:0] q);
    re[d] = r; we[d] = w; ad[d] = a; sd[d] = s; alu[d] = al; wr[d] = g; ra[d] = q;
  endtask

  task automatic send(input int d, input logic r, input logic w, input logic [15:0] a,
                      input logic [31:0] s, input logic [31:0] al, input logic g, input logic [2:0] q);
    logic acc;
    int   n;
    set_op(d, r, w, a, s, al, g, q);
    iv[d] = 1'b1;
    n     = 0;
    acc   = 1'b0;
    while (!acc && n < 50) begin
      cycle(d, acc);
      n++;
    end
    if (!acc) begin
      tests_run++;
      failed++;
      $error("FAIL accept_timeout dut%0d: observed no accept expected accept within 50 cycles", d);
    end
    iv[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int n);
    logic acc;
    iv[d] = 1'b0;
    for (int i = 0; i < n; i++) cycle(d, acc);
  endtask

  task automatic reset_dut(input int d, input bit store_during);
    rst[d] = 1'b1;
    #1;
    chk("rst_out_valid", d, 32'(ov[d]), 32'h0);
    chk("rst_write_reg_out", d, 32'(wro[d]), 32'h0);
    chk("rst_addr_error", d, 32'(aerr[d]), 32'h0);
    chk("rst_read_out_data", d, rdata_of(d), 32'h0);
    chk("rst_reg_address_out", d, 32'(rao[d]), 32'h0);
    clear_slots(d);
    if (store_during) begin
      set_op(d, 1'b0, 1'b1, 16'd7, 32'h5A5A_A5A5, 32'h0, 1'b0, 3'd0);
      iv[d] = 1'b1;
    end
    @(posedge clk);
    #1;
    rst[d] = 1'b0;
    iv[d]  = 1'b0;
    we[d]  = 1'b0;
  endtask

  task automatic run_dut(input int d);
    logic        acc;
    int          cyc;
    int          k;
    int          sent;
    logic [31:0] wide;
    mem_m.delete();
    ordy[d] = 1'b1;
    reset_dut(d, 1'b0);

    // store then immediate load of the same word
    send(d, 1'b0, 1'b1, 16'd5, 32'h1234, 32'h0, 1'b0, 3'd0);
    send(d, 1'b1, 1'b0, 16'd5, 32'h0, 32'h0, 1'b1, 3'd2);
    idle(d, 3);

    // ALU pass-through with register write-back
    wide = (d == 2) ? 32'hDEAD_BEEF : 32'h0000_BEEF;
    send(d, 1'b0, 1'b0, 16'd9, 32'h0, wide, 1'b1, 3'd6);
    idle(d, 3);

    for (int a = 0; a < 16; a++) send(d, 1'b0, 1'b1, 16'(a), $urandom, 32'h0, 1'b0, 3'(a));

    // three back-to-back loads against a 4-cycle output stall
    ordy[d] = 1'b0;
    sent    = 0;
    cyc     = 0;
    while (sent < 3 && cyc < 40) begin
      if (!iv[d]) begin
        set_op(d, 1'b1, 1'b0, 16'(sent + 1), 32'h0, 32'h0, 1'b1, 3'(sent + 1));
        iv[d] = 1'b1;
      end
      cycle(d, acc);
      if (acc) begin
        iv[d] = 1'b0;
        sent++;
      end
      cyc++;
      if (cyc == 5) ordy[d] = 1'b1;
    end
    chk("stall_loads_sent", d, 32'(sent), 32'd3);
    ordy[d] = 1'b1;
    idle(d, 3);

    // out-of-range store and load; word 0 must be untouched
    send(d, 1'b0, 1'b1, 16'd4096, 32'hFFFF, 32'h0, 1'b1, 3'd1);
    send(d, 1'b1, 1'b0, 16'd4096, 32'h0, 32'h0, 1'b1, 3'd2);
    send(d, 1'b1, 1'b0, 16'd0, 32'h0, 32'h0, 1'b0, 3'd3);
    send(d, 1'b1, 1'b1, 16'hFFFF, 32'h1111, 32'h0, 1'b0, 3'd4);
    idle(d, 3);

    // reset with operations in flight; a store driven during reset must not land
    send(d, 1'b0, 1'b1, 16'd20, 32'hC0DE_0042, 32'h0, 1'b0, 3'd0);
    send(d, 1'b1, 1'b0, 16'd3, 32'h0, 32'h0, 1'b1, 3'd5);
    reset_dut(d, 1'b1);
    send(d, 1'b1, 1'b0, 16'd20, 32'h0, 32'h0, 1'b1, 3'd7);
    send(d, 1'b1, 1'b0, 16'd7, 32'h0, 32'h0, 1'b1, 3'd1);
    idle(d, 3);

    // randomized traffic with upstream holding each operation until accepted
    for (int i = 0; i < 300; i++) begin
      if (!iv[d] && $urandom_range(0, 3) != 0) begin
        k = int'($urandom_range(0, 9));
        if (k < 7)      ad[d] = 16'($urandom_range(0, 31));
        else if (k < 9) ad[d] = 16'($urandom_range(4090, 4100));
        else            ad[d] = 16'hFFFF;
        k      = int'($urandom_range(0, 3));
        re[d]  = (k == 1) || (k == 3);
        we[d]  = (k == 2) || (k == 3);
        sd[d]  = $urandom;
        alu[d] = $urandom;
        wr[d]  = 1'($urandom_range(0, 1));
        ra[d]  = 3'($urandom_range(0, 7));
        iv[d]  = 1'b1;
      end
      ordy[d] = ($urandom_range(0, 9) < 7);
      cycle(d, acc);
      if (acc) iv[d] = 1'b0;
    end
    ordy[d] = 1'b1;
    idle(d, 4);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; iv[d] = 1'b0; ordy[d] = 1'b1;
      set_op(d, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 3'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;
    for (int d = 0; d < ND; d++) run_dut(d);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_stage_p.md
MEM_STAGE_P -- requirements
Module: mem_stage_p

Interface
REQ-001 Parameter DATA_W, default 16, data path width in bits.
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Parameter REG_ADDR_W, default 3, register-file index width.
REQ-004 Parameter MEM_DEPTH, default 4096, number of DATA_W words in the internal RAM; MEM_DEPTH <= 2**ADDR_W.
REQ-005 Parameter READ_LATENCY, default 1, legal values 1 or 2, number of pipeline registers from accept to output.
REQ-006 Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  upstream operation present.
- in_ready  out  1  stage accepts the operation this cycle.
- address  in  ADDR_W  memory word address.
- store_data  in  DATA_W  write data.
- alu_result  in  DATA_W  pass-through result for non-memory operations.
- read_enable  in  1  load.
- write_enable  in  1  store.
- write_reg  in  1  destination write-back request.
- reg_address  in  REG_ADDR_W  destination register.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- read_out_data  out  DATA_W  write-back data.
- write_reg_out  out  1  delayed write_reg.
- reg_address_out  out  REG_ADDR_W  delayed reg_address.
- addr_error  out  1  the output operation addressed outside MEM_DEPTH.

Function
REQ-007 advance = !out_valid || out_ready; in_ready SHALL equal advance, combinationally.
REQ-008 An operation is accepted on a rising edge where in_valid && in_ready.
REQ-009 Accepted operations SHALL appear at the output exactly READ_LATENCY accepting/advancing edges later, in order, with no loss or duplication.
REQ-010 When advance is 0, every pipeline register, including the RAM read register, SHALL hold; the output fields SHALL stay stable while out_valid && !out_ready.
REQ-011 Empty slots SHALL propagate as bubbles: stage valid bits shift on advance, with in_valid && in_ready feeding stage 1.
REQ-012 Store: on the accept edge with write_enable=1 and address < MEM_DEPTH, RAM[address] <= store_data; read_out_data for that operation = store_data.
REQ-013 Load: read_enable=1, write_enable=0, address < MEM_DEPTH: read_out_data = RAM[address] as of after all earlier-accepted stores (load directly following a store to the same address returns the new data).
REQ-014 Neither enable asserted: read_out_data = alu_result, full DATA_W width.
REQ-015 Both enables asserted: treated as a store per REQ-012.
REQ-016 address >= MEM_DEPTH with either enable asserted: no RAM write; read_out_data = 0; addr_error=1 for that output beat; otherwise addr_error=0.
REQ-017 write_reg_out and reg_address_out SHALL travel with their operation unmodified; a bubble output has write_reg_out=0.
REQ-018 RAM contents are not initialised; only its control path is reset.

Reset
REQ-019 Asserting reset SHALL immediately clear every stage valid bit, out_valid, write_reg_out, and addr_error, and SHALL set read_out_data and reg_address_out to 0.
REQ-020 Reset asserted mid-operation SHALL drop in-flight operations without completing them; a store accepted before reset keeps its RAM write.
REQ-021 No RAM write SHALL occur while reset is high; in_ready may be 1 during reset, but no operation is accepted.

Structure
REQ-022 A shared package SHALL hold the default widths and depth, and the legal READ_LATENCY values.
REQ-023 The RAM SHALL be one sub-module, mem_stage_ram: single port, synchronous write, and a read register with clock enable (enable = advance). The write-first rule of REQ-013 is implemented there.

Verification
REQ-024 Store 0x1234 to address 5, then load address 5 on the next cycle with out_ready=1 -> second output read_out_data=0x1234, addr_error=0.
REQ-025 No enable, alu_result=0xBEEF, write_reg=1, reg_address=6 -> output 0xBEEF, write_reg_out=1, reg_address_out=6 after READ_LATENCY advances.
REQ-026 Three back-to-back loads with out_ready held 0 for 4 cycles -> in_ready=0, output frozen on the first load, then all three are delivered in order.
REQ-027 Store to address MEM_DEPTH (4096) with store_data=0xFFFF, then load 4096 -> no RAM change, read_out_data=0, addr_error=1 on both beats.
REQ-028 Reset asserted with two operations in flight -> out_valid=0 immediately; after release, the first new operation's result is correct.
REQ-029 Run REQ-024 through REQ-028 at READ_LATENCY=1 and READ_LATENCY=2, and at DATA_W=32, against a reference model.
